nota_controller: RTL

- Sequencing controller for the board's grade-display path.
- Collects NNOTAS 4-bit grades entered on the switches, one per rising edge of an enter switch, and accumulates their sum.
- Computes the integer average by sequential repeated subtraction, then drives the 7-segment display with the letter code A/F/P.
- Sits between the board switches (SWI) and the SEG/LED outputs in top; replaces the purely combinational letter selection.

---
 rtl/nota_controller.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/nota_controller.sv
`default_nettype none
// ============================================================================
//  Module      : nota_controller
//  Description : Collects NNOTAS grades entered on the board switches,
//                averages them by repeated subtraction, and shows the
//                A/F/P letter code on the 7-segment display.
//  Revision    : 1.0 - initial release
// ============================================================================
module nota_controller #(
    parameter int          NBITS_NOTA = 4,
    parameter int          NNOTAS     = 4,
    parameter int          NOTA_MAX   = 10,
    parameter logic [7:0]  LETRA_A    = 8'b01110111,
    parameter logic [7:0]  LETRA_F    = 8'b01110001,
    parameter logic [7:0]  LETRA_P    = 8'b01110011
) (
    input  logic                  clk_2,
    input  logic                  reset_n,
    input  logic [NBITS_NOTA-1:0] nota_in,
    input  logic                  enter,
    input  logic                  clear,
    output logic [7:0]            SEG,
    output logic [7:0]            LED,
    output logic [NBITS_NOTA-1:0] media,
    output logic                  done
);

    localparam int SUM_W = 8;
    localparam int CNT_W = 5;

    localparam logic [CNT_W-1:0]      c_nnotas_cnt = CNT_W'(NNOTAS);
    localparam logic [SUM_W-1:0]      c_nnotas_sum = SUM_W'(NNOTAS);
    localparam logic [NBITS_NOTA-1:0] c_nota_max   = NBITS_NOTA'(NOTA_MAX);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DIVIDE  = 2'd1,
        SHOW    = 2'd2,
        UNUSED  = 2'd3
    } state_t;

    state_t           r_state;
    logic [SUM_W-1:0] r_sum;
    logic [CNT_W-1:0] r_count;
    logic [SUM_W-1:0] r_quo;
    logic [SUM_W-1:0] r_rem;
    logic             r_err;
    logic             r_enter_q;
    logic             r_clear_q;

    logic             w_enter_rise;
    logic             w_clear_rise;
    logic [SUM_W-1:0] w_sum_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [7:0]       w_letter;

    // Switch edge events and the next accumulator/counter values
    always_comb begin
        w_enter_rise = enter & ~r_enter_q;
        w_clear_rise = clear & ~r_clear_q;
        w_sum_next   = r_sum + SUM_W'(nota_in);
        w_cnt_next   = r_count + CNT_W'(1);
        if (r_quo >= SUM_W'(7))
            w_letter = LETRA_A;
        else if (r_quo >= SUM_W'(4))
            w_letter = LETRA_F;
        else
            w_letter = LETRA_P;
    end

    // Sequencing FSM with registered display outputs
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= COLLECT;
            r_sum     <= '0;
            r_count   <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_err     <= 1'b0;
            r_enter_q <= 1'b0;
            r_clear_q <= 1'b0;
            SEG       <= '0;
            media     <= '0;
            done      <= 1'b0;
        end else begin
            r_enter_q <= enter;
            r_clear_q <= clear;
            if (w_clear_rise) begin
                // Abort wins over everything, including a simultaneous enter
                r_state <= COLLECT;
                r_sum   <= '0;
                r_count <= '0;
                r_err   <= 1'b0;
                r_quo   <= '0;
                SEG     <= '0;
                media   <= '0;
                done    <= 1'b0;
            end else begin
                case (r_state)
                    COLLECT: begin
                        if (w_enter_rise) begin
                            if (nota_in > c_nota_max) begin
                                r_err <= 1'b1;
                            end else begin
                                r_sum   <= w_sum_next;
                                r_count <= w_cnt_next;
                                r_err   <= 1'b0;
                                if (w_cnt_next == c_nnotas_cnt) begin
                                    r_state <= DIVIDE;
                                    r_rem   <= w_sum_next;
                                    r_quo   <= '0;
                                end
                            end
                        end
                    end
                    DIVIDE: begin
                        if (r_rem >= c_nnotas_sum) begin
                            r_rem <= r_rem - c_nnotas_sum;
                            r_quo <= r_quo + SUM_W'(1);
                        end else begin
                            r_state <= SHOW;
                            media   <= r_quo[NBITS_NOTA-1:0];
                            SEG     <= w_letter;
                            done    <= 1'b1;
                        end
                    end
                    SHOW: begin
                        // A new enter edge starts a fresh round; its grade is dropped
                        if (w_enter_rise) begin
                            r_state <= COLLECT;
                            r_sum   <= '0;
                            r_count <= '0;
                            r_err   <= 1'b0;
                            SEG     <= '0;
                            media   <= '0;
                            done    <= 1'b0;
                        end
                    end
                    default: begin
                        // Unreachable encoding: recover to a clean COLLECT
                        r_state   <= COLLECT;
                        r_sum     <= '0;
                        r_count   <= '0;
                        r_quo     <= '0;
                        r_rem     <= '0;
                        r_err     <= 1'b0;
                        r_enter_q <= 1'b0;
                        r_clear_q <= 1'b0;
                        SEG       <= '0;
                        media     <= '0;
                        done      <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Status LEDs: state, error flag, grades collected so far
    always_comb begin
        LED = {r_state, r_err, r_count};
    end

endmodule
`default_nettype wire
